// File: rtl/mips_sequencer.sv
// Multi-cycle control sequencer for the MIPS CPU. It owns the instruction state,
// handles bus stalls, multi-cycle MULT/DIV, branch-delay-slot redirect and HALT.
module mips_sequencer #(
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              waitrequest,
  input  logic              pc_zero,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              is_muldiv,
  input  logic              is_branch,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [2:0]        state,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_load,
  output logic              pc_en,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              delay_slot,
  output logic              muldiv_busy,
  output logic              active
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC1  = 3'd1,
    S_EXEC2  = 3'd2,
    S_MDWAIT = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic       pending;
  logic [7:0] md_cnt;
  logic       exec1_exit;
  logic       md_start;
  logic       latch_branch;
  logic       rd_raw;
  logic       wr_raw;
  logic       irl_raw;
  logic       pen_raw;

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    nxt_state  = cur_state;
    rd_raw     = 1'b0;
    wr_raw     = 1'b0;
    irl_raw    = 1'b0;
    pen_raw    = 1'b0;
    exec1_exit = 1'b0;
    md_start   = 1'b0;
    case (cur_state)
      S_FETCH: begin
        if (pc_zero) begin
          nxt_state = S_HALT;
        end else begin
          rd_raw = 1'b1;
          if (!waitrequest) begin
            irl_raw   = 1'b1;
            nxt_state = S_EXEC1;
          end
        end
      end
      S_EXEC1: begin
        if (is_load) begin
          rd_raw = 1'b1;
          if (!waitrequest) begin
            exec1_exit = 1'b1;
            nxt_state  = S_EXEC2;
          end
        end else if (is_store) begin
          wr_raw = 1'b1;
          if (!waitrequest) begin
            exec1_exit = 1'b1;
            pen_raw    = 1'b1;
            nxt_state  = S_FETCH;
          end
        end else if (is_muldiv) begin
          exec1_exit = 1'b1;
          md_start   = 1'b1;
          nxt_state  = S_MDWAIT;
        end else begin
          exec1_exit = 1'b1;
          pen_raw    = 1'b1;
          nxt_state  = S_FETCH;
        end
      end
      S_EXEC2: begin
        pen_raw   = 1'b1;
        nxt_state = S_FETCH;
      end
      S_MDWAIT: begin
        if (md_cnt == 8'd0) begin
          pen_raw   = 1'b1;
          nxt_state = S_FETCH;
        end
      end
      S_HALT:  nxt_state = S_HALT;
      default: nxt_state = S_FETCH;
    endcase
  end

  // Strobes and enables are suppressed while reset is held so nothing leaks onto the bus.
  assign mem_read  = rd_raw  & reset_n;
  assign mem_write = wr_raw  & reset_n;
  assign ir_load   = irl_raw & reset_n;
  assign pc_en     = pen_raw & reset_n;
  assign pc_sel    = pc_en & pending;

  // A branch sitting in a delay slot (pending already set) never re-arms the latch.
  assign latch_branch = exec1_exit & is_branch & branch_taken & ~pending;

  assign state       = cur_state;
  assign delay_slot  = pending;
  assign muldiv_busy = (cur_state == S_MDWAIT);
  assign active      = (cur_state != S_HALT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= S_FETCH;
      pending   <= 1'b0;
      pc_target <= '0;
      md_cnt    <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      cur_state <= nxt_state;
      if (latch_branch) begin
        pc_target <= branch_target;
        pending   <= 1'b1;
      end else if (pc_en && pending) begin
        pending <= 1'b0;
      end
      if (md_start) begin
        md_cnt <= MD_LOAD;
      end else if (cur_state == S_MDWAIT && md_cnt != 8'd0) begin
        md_cnt <= md_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_sequencer.sv
// Scoreboard bench for mips_sequencer: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_mips_sequencer;

  typedef enum int {C_NOP, C_LD, C_ST, C_MD, C_BT, C_BN} cls_e;

  typedef struct {
    string       name;
    logic [42:0] v;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        waitrequest;
  logic        pc_zero;
  logic        is_load;
  logic        is_store;
  logic        is_muldiv;
  logic        is_branch;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [2:0]  state;
  logic        mem_read;
  logic        mem_write;
  logic        ir_load;
  logic        pc_en;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        delay_slot;
  logic        muldiv_busy;
  logic        active;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mips_sequencer #(.MULDIV_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .pc_zero(pc_zero),
    .is_load(is_load), .is_store(is_store), .is_muldiv(is_muldiv),
    .is_branch(is_branch), .branch_taken(branch_taken), .branch_target(branch_target),
    .state(state), .mem_read(mem_read), .mem_write(mem_write), .ir_load(ir_load),
    .pc_en(pc_en), .pc_sel(pc_sel), .pc_target(pc_target), .delay_slot(delay_slot),
    .muldiv_busy(muldiv_busy), .active(active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [42:0] act, input logic [42:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input logic wr, input logic pz, input cls_e c, input logic [31:0] tgt);
    waitrequest   = wr;
    pc_zero       = pz;
    is_load       = (c == C_LD);
    is_store      = (c == C_ST);
    is_muldiv     = (c == C_MD);
    is_branch     = (c == C_BT) || (c == C_BN);
    branch_taken  = (c == C_BT);
    branch_target = tgt;
  endtask

  // Flags order: mem_read mem_write ir_load pc_en pc_sel delay_slot muldiv_busy active
  task automatic ex(input string name, input logic [2:0] st, input logic [7:0] fl,
                    input logic [31:0] pt);
    exp_t e;
    e.name = name;
    e.v    = {st, fl, pt};
    q.push_back(e);
  endtask

  // Drive one cycle's inputs, queue its expected outputs, then advance one clock.
  task automatic cyc(input string name, input logic wr, input logic pz, input cls_e c,
                     input logic [31:0] tgt, input logic [2:0] st, input logic [7:0] fl,
                     input logic [31:0] pt);
    drv(wr, pz, c, tgt);
    ex(name, st, fl, pt);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, {state, mem_read, mem_write, ir_load, pc_en, pc_sel,
                       delay_slot, muldiv_busy, active, pc_target}, e.v);
        check("rd_wr_excl", {42'd0, mem_read & mem_write}, 43'd0);
      end
    end
  end

  initial begin : stimulus
    reset_n = 1'b1;
    drv(1'b0, 1'b0, C_NOP, 32'h0);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    ex("reset", 3'd0, 8'b00000001, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      cyc("nop_fetch", 0, 0, C_NOP, 32'h0, 3'd0, 8'b10100001, 32'h0);
      cyc("nop_exec1", 0, 0, C_NOP, 32'h0, 3'd1, 8'b00010001, 32'h0);
    end

    for (int i = 0; i < 3; i++)
      cyc("ld_fetch_wait", 1, 0, C_LD, 32'h0, 3'd0, 8'b10000001, 32'h0);
    cyc("ld_fetch",      0, 0, C_LD, 32'h0, 3'd0, 8'b10100001, 32'h0);
    cyc("ld_exec1_wait", 1, 0, C_LD, 32'h0, 3'd1, 8'b10000001, 32'h0);
    cyc("ld_exec1_wait", 1, 0, C_LD, 32'h0, 3'd1, 8'b10000001, 32'h0);
    cyc("ld_exec1",      0, 0, C_LD, 32'h0, 3'd1, 8'b10000001, 32'h0);
    cyc("ld_exec2",      0, 0, C_LD, 32'h0, 3'd2, 8'b00010001, 32'h0);

    cyc("st_fetch",      0, 0, C_ST, 32'h0, 3'd0, 8'b10100001, 32'h0);
    cyc("st_exec1_wait", 1, 0, C_ST, 32'h0, 3'd1, 8'b01000001, 32'h0);
    cyc("st_exec1",      0, 0, C_ST, 32'h0, 3'd1, 8'b01010001, 32'h0);

    cyc("br_fetch",      0, 0, C_BT,  32'h40, 3'd0, 8'b10100001, 32'h0);
    cyc("br_exec1",      0, 0, C_BT,  32'h40, 3'd1, 8'b00010001, 32'h0);
    cyc("slot_fetch",    0, 0, C_NOP, 32'h0,  3'd0, 8'b10100101, 32'h40);
    cyc("slot_exec1",    0, 0, C_NOP, 32'h0,  3'd1, 8'b00011101, 32'h40);
    cyc("post_slot",     0, 0, C_NOP, 32'h0,  3'd0, 8'b10100001, 32'h40);
    cyc("post_slot_ex",  0, 0, C_NOP, 32'h0,  3'd1, 8'b00010001, 32'h40);

    cyc("br2_fetch",     0, 0, C_BT, 32'h80, 3'd0, 8'b10100001, 32'h40);
    cyc("br2_exec1",     0, 0, C_BT, 32'h80, 3'd1, 8'b00010001, 32'h40);
    cyc("slotbr_fetch",  0, 0, C_BT, 32'hC0, 3'd0, 8'b10100101, 32'h80);
    cyc("slotbr_exec1",  0, 0, C_BT, 32'hC0, 3'd1, 8'b00011101, 32'h80);
    cyc("slotbr_after",  0, 0, C_NOP, 32'h0, 3'd0, 8'b10100001, 32'h80);

    cyc("brn_exec1",     0, 0, C_BN, 32'h200, 3'd1, 8'b00010001, 32'h80);
    cyc("brn_after",     0, 0, C_NOP, 32'h0,  3'd0, 8'b10100001, 32'h80);

    cyc("md_exec1",      0, 0, C_MD, 32'h0, 3'd1, 8'b00000001, 32'h80);
    cyc("md_wait3",      0, 0, C_MD, 32'h0, 3'd3, 8'b00000011, 32'h80);
    cyc("md_wait2",      0, 0, C_MD, 32'h0, 3'd3, 8'b00000011, 32'h80);
    cyc("md_wait1",      0, 0, C_MD, 32'h0, 3'd3, 8'b00000011, 32'h80);
    cyc("md_wait0",      0, 0, C_MD, 32'h0, 3'd3, 8'b00010011, 32'h80);
    cyc("md_after",      0, 0, C_NOP, 32'h0, 3'd0, 8'b10100001, 32'h80);

    cyc("br3_exec1",     0, 0, C_BT, 32'h100, 3'd1, 8'b00010001, 32'h80);
    cyc("slotmd_fetch",  0, 0, C_MD, 32'h0,   3'd0, 8'b10100101, 32'h100);
    cyc("slotmd_exec1",  0, 0, C_MD, 32'h0,   3'd1, 8'b00000101, 32'h100);
    cyc("slotmd_wait",   0, 0, C_MD, 32'h0,   3'd3, 8'b00000111, 32'h100);
    reset_n = 1'b0;
    drv(1'b1, 1'b0, C_MD, 32'h0);
    ex("midop_reset", 3'd0, 8'b00000001, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc("rst_fetch",     1, 0, C_NOP, 32'h0, 3'd0, 8'b10000001, 32'h0);

    cyc("halt_fetch",    0, 1, C_NOP, 32'h0, 3'd0, 8'b00000001, 32'h0);
    for (int i = 0; i < 20; i++)
      cyc("halt_hold", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          cls_e'($urandom_range(0, 5)), $urandom, 3'd4, 8'b00000000, 32'h0);

    @(negedge clk);
    #1;
    check("queue_drained", 43'(q.size()), 43'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_sequencer.md
# mips_sequencer

Multi-cycle control sequencer for the MIPS CPU. It owns the instruction state register that the decoder previously received as an input. It adds four things the earlier two-bit FETCH/EXEC1/EXEC2 scheme lacks: memory-wait stalls in every bus state, a parametrised multi-cycle MULT/DIV wait state, a branch-delay-slot target latch, and an absorbing HALT. It sits between the decoder (instruction class flags in), the Avalon memory interface (`waitrequest` in, `mem_read`/`mem_write` out) and the PC/IR registers (enables out).

## Interface
- `MULDIV_CYCLES`, 32: cycles spent in MDWAIT per MULT/MULTU/DIV/DIVU; legal range 1..255.
- `ADDR_W`, 32: width of the branch target path.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `waitrequest` in 1: memory busy; the current bus access has not completed.
- `pc_zero` in 1: current PC equals 0x0.
- `is_load`, `is_store`, `is_muldiv`, `is_branch` in 1 each: decoder class flags for the instruction held in IR. At most one of load/store/muldiv is set.
- `branch_taken` in 1: condition result for a branch or jump; qualified by `is_branch`.
- `branch_target` in `ADDR_W`: computed branch or jump destination.
- `state` out 3: FETCH=0, EXEC1=1, EXEC2=2, MDWAIT=3, HALT=4.
- `mem_read`, `mem_write` out 1 each: Avalon read/write strobes.
- `ir_load` out 1: capture the fetched word into IR.
- `pc_en` out 1: update PC this cycle.
- `pc_sel` out 1: 0 selects PC+4; 1 selects `pc_target`.
- `pc_target` out `ADDR_W`: latched branch target.
- `delay_slot` out 1: a taken branch is pending, so the current or next instruction is its delay slot.
- `muldiv_busy` out 1: high in MDWAIT.
- `active` out 1: low only in HALT.

## Operation
- **Registered state.** The block holds the state register, `pc_target` register, pending flag (driven onto `delay_slot`), and an 8-bit down-counter `md_cnt`. All other outputs are combinational from the state plus inputs.
- **FETCH:**
  - `pc_zero`=1: `mem_read`=0; next state HALT.
  - Otherwise `mem_read`=1. Stay in FETCH while `waitrequest`=1.
  - When `waitrequest`=0: `ir_load`=1; go to EXEC1.
- **EXEC1, load:** `mem_read`=1; hold while `waitrequest`=1, then go to EXEC2. No `pc_en` in EXEC1.
- **EXEC1, store:** `mem_write`=1; hold while `waitrequest`=1, then `pc_en`=1 and go to FETCH.
- **EXEC1, muldiv:** load `md_cnt` with `MULDIV_CYCLES`-1; go to MDWAIT. No `pc_en` in EXEC1.
- **EXEC1, other:** `pc_en`=1; go to FETCH.
- **Branch latch.** In EXEC1, if `is_branch` and `branch_taken`, and pending=0: on the exit cycle latch `pc_target` ← `branch_target` and set pending=1.
  - The branch's own PC update uses `pc_sel`=0.
- **Delay-slot redirect.** While pending=1, the next `pc_en` (the delay-slot instruction's) drives `pc_sel`=1 and clears pending on the same edge.
- **Branch inside a delay slot.** Ignored: neither `pc_target` nor pending changes.
- **EXEC2:** `pc_en`=1 with `pc_sel` per the pending rule; go to FETCH.
- **MDWAIT:** `muldiv_busy`=1. If `md_cnt`≠0, decrement. If `md_cnt`=0, `pc_en`=1 and go to FETCH.
- **HALT:** absorbing. All strobes and enables are 0, `active`=0. Only `reset_n` exits.
- **Reset values:**
  - state=FETCH, pending=0, `pc_target`=0, `md_cnt`=0.
  - Outputs: `active`=1, `delay_slot`=0, `muldiv_busy`=0.
  - `mem_read` follows FETCH decode once reset deasserts.
- **Reset mid-operation:** reset asserted during any state, including a stalled bus access or MDWAIT, aborts immediately. Pending and counter are cleared; no strobe is held.

## Timing
- Cycle counts assume zero wait states:
  - ALU, jump, branch: 2 cycles.
  - Store: 2 cycles.
  - Load: 3 cycles.
  - MULT/DIV: 2+`MULDIV_CYCLES` cycles.
- Each cycle with `waitrequest`=1 during FETCH or a load/store in EXEC1 adds exactly one cycle. Strobe, address and control remain stable throughout.
- `ir_load`, `pc_en` and `pc_sel` are Mealy outputs, combinational on `waitrequest` in the same cycle. State, pending and `pc_target` update on the following edge.
- `mem_read` and `mem_write` are never both 1. Exactly one `pc_en` pulse occurs per retired instruction.

## Test plan
- **Reset then NOP stream, no waits.**
  - Stimulus: reset, then NOPs with `waitrequest`=0.
  - Required: state sequence 0,1,0,1,…; one `pc_en` every 2 cycles; `pc_sel`=0 throughout.
- **Load with wait states.**
  - Stimulus: load with `waitrequest`=1 for 3 cycles in FETCH and 2 cycles in EXEC1.
  - Required: `mem_read` held high; `pc_en` fires once in EXEC2; total 8 cycles.
- **Taken branch plus delay slot.**
  - Stimulus: taken branch with `branch_target`=0x0000_0040, followed by an ADDU.
  - Required: the branch's `pc_en` has `pc_sel`=0; `delay_slot`=1 during the ADDU; the ADDU's `pc_en` has `pc_sel`=1 and `pc_target`=0x40; `delay_slot`=0 afterward.
- **MULT with `MULDIV_CYCLES`=4.**
  - Stimulus: one MULT.
  - Required: `muldiv_busy` high exactly 4 cycles; `pc_en` in the last MDWAIT cycle; 6 cycles total.
- **Halt.**
  - Stimulus: `pc_zero`=1 in FETCH.
  - Required: `mem_read`=0; next cycle state=4, `active`=0; remains there for 20 cycles regardless of inputs.
- **Reset mid-operation.**
  - Stimulus: assert `reset_n`=0 during MDWAIT with pending=1.
  - Required: immediate state=0, `delay_slot`=0, `muldiv_busy`=0 without waiting for a clock edge.
